// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control FSM (Moore); optional bne support via CTRL_BNE_EN.
// Latency: outputs follow the state register; instructions take 3-5 cycles (beq 3, lw 5).
// No backpressure: advances every cycle; reset forces FETCH and masks all write enables.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t     cur, nxt;
    logic       pc_update, branch, taken;
    logic       mem_write_raw, ir_write_raw, reg_write_raw;
    logic [1:0] alu_op;

    always_ff @(posedge clk) begin
        if (reset) cur <= S_FETCH;
        else       cur <= nxt;
    end

    always_comb begin
        nxt           = S_FETCH;
        pc_update     = 1'b0;
        branch        = 1'b0;
        alu_op        = 2'b00;
        AdrSrc        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        case (cur)
            S_FETCH: begin
                nxt          = S_DECODE;
                ir_write_raw = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                pc_update    = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_R:         nxt = S_EXECUTER;
                    OP_I:         nxt = S_EXECUTEI;
                    OP_BR:        nxt = S_BEQ;
                    OP_JAL:       nxt = S_JAL;
                    default:      nxt = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                nxt     = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                nxt    = S_MEMWB;
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                nxt     = S_ALUWB;
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            S_EXECUTEI: begin
                nxt     = S_ALUWB;
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_ALUWB: reg_write_raw = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            S_JAL: begin
                nxt       = S_ALUWB;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: nxt = S_FETCH;
        endcase
    end

`ifdef CTRL_BNE_EN
    // funct3[0] distinguishes bne from beq on the shared branch opcode
    assign taken = zero ^ funct3[0];
`else
    assign taken = zero;
`endif

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BR:   ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign PCWrite  = (pc_update | (branch & taken)) & ~reset;
    assign IRWrite  = ir_write_raw & ~reset;
    assign RegWrite = reg_write_raw & ~reset;
    assign MemWrite = mem_write_raw & ~reset;
    assign state    = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed and random instructions vs. an instruction-level model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;
    logic [15:0] obs;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .state(state)
    );

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ALUControl, ImmSrc, RegWrite};

    // State visited at each step of one instruction, -1 once it has retired.
    function automatic int trace_state(input logic [6:0] o, input int step);
        int seq[$];
        case (o)
            7'b0000011: seq = '{0, 1, 2, 3, 4};
            7'b0100011: seq = '{0, 1, 2, 5};
            7'b0110011: seq = '{0, 1, 6, 8};
            7'b0010011: seq = '{0, 1, 7, 8};
            7'b1100011: seq = '{0, 1, 9};
            7'b1101111: seq = '{0, 1, 10, 8};
            default:    seq = '{0, 1};
        endcase
        return (step < seq.size()) ? seq[step] : -1;
    endfunction

    function automatic logic [2:0] arith_alu(input logic [2:0] f3, input logic op5, input logic f7);
        case (f3)
            3'b000:  return (op5 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [15:0] exp_out(input int st, input logic [6:0] o, input logic [2:0] f3,
                                            input logic f7, input logic z, input logic rst);
        logic pcw, adr, mw, irw, rw, tk;
        logic [1:0] res, sa, sb, imm;
        logic [2:0] aluc;
        {pcw, adr, mw, irw, rw} = 5'b0;
        {res, sa, sb} = 6'b0;
        aluc = 3'b000;
`ifdef CTRL_BNE_EN
        tk = z ^ f3[0];
`else
        tk = z;
`endif
        case (st)
            0:  begin irw = 1; sb = 2'b10; res = 2'b10; pcw = 1; end
            1:  begin sa = 2'b01; sb = 2'b01; end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  adr = 1;
            4:  begin res = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2'b10; aluc = arith_alu(f3, o[5], f7); end
            7:  begin sa = 2'b10; sb = 2'b01; aluc = arith_alu(f3, o[5], f7); end
            8:  rw = 1;
            9:  begin sa = 2'b10; aluc = 3'b001; pcw = tk; end
            10: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            default: ;
        endcase
        case (o)
            7'b0100011: imm = 2'b01;
            7'b1100011: imm = 2'b10;
            7'b1101111: imm = 2'b11;
            default:    imm = 2'b00;
        endcase
        if (rst) {pcw, mw, irw, rw} = 4'b0;
        return {pcw, adr, mw, irw, res, sa, sb, aluc, imm, rw};
    endfunction

    // Called at a falling edge with the DUT in FETCH; returns at the falling edge of the next FETCH.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input string name);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        for (int s = 0; trace_state(o, s) >= 0; s++) begin
            int es;
            es = trace_state(o, s);
            #1;
            checks++;
            if (state !== 4'(es)) begin
                failures++;
                $display("FAIL %s state step %0d: got %0d want %0d", name, s, state, es);
            end
            checks++;
            if (obs !== exp_out(es, o, f3, f7, z, 1'b0)) begin
                failures++;
                $display("FAIL %s outputs step %0d state %0d: got %h want %h",
                         name, s, es, obs, exp_out(es, o, f3, f7, z, 1'b0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (state !== 4'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d want 0", state);
        end
        checks++;
        if (obs !== exp_out(0, op, funct3, funct7b5, zero, 1'b1)) begin
            failures++;
            $display("FAIL reset_outputs: got %h want %h", obs, exp_out(0, op, funct3, funct7b5, zero, 1'b1));
        end
        reset = 1'b0;
    endtask

    task automatic test_lw();       run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, "lw");       endtask
    task automatic test_sw();       run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, "sw");       endtask

    task automatic test_alu();
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, "r_sub");
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, "i_addi");
        run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, "r_and");
        run_instr(7'b0010011, 3'b010, 1'b0, 1'b0, "i_slti");
    endtask

    task automatic test_branch();
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, "beq_taken");
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, "beq_not_taken");
        run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, "bne_zero0");
        run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, "bne_zero1");
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, "jal");
    endtask

    task automatic test_illegal_and_reset();
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, "illegal");
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 4'd3) begin
            failures++;
            $display("FAIL mid_reset_hold_state: got %0d want 3", state);
        end
        checks++;
        if (obs !== exp_out(3, op, funct3, funct7b5, zero, 1'b1)) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %h want %h", obs, exp_out(3, op, funct3, funct7b5, zero, 1'b1));
        end
        @(negedge clk);
        #1;
        checks++;
        if (state !== 4'd0) begin
            failures++;
            $display("FAIL mid_reset_state: got %0d want 0", state);
        end
        checks++;
        if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_writes: got %b want 0000", {PCWrite, IRWrite, RegWrite, MemWrite});
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [6:0] ops[8];
        logic [6:0] o;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b1111111, 7'b0000000};
        for (int i = 0; i < 60; i++) begin
            int k;
            k = $urandom_range(0, 7);
            o = (k == 7) ? 7'($urandom_range(0, 127)) : ops[k];
            run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_alu();
        test_branch();
        test_illegal_and_reset();
        test_random();
        #1;
        checks++;
        if (state !== 4'd0) begin
            failures++;
            $display("FAIL final_state: got %0d want 0", state);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 No parameters; all widths fixed.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  7  instruction opcode bits [6:0].
REQ-005 funct3  in  3  instruction bits [14:12].
REQ-006 funct7b5  in  1  instruction bit 30.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 PCWrite  out  1  PC register enable.
REQ-009 AdrSrc  out  1  memory address select: 0=PC, 1=result.
REQ-010 MemWrite  out  1  data memory write enable.
REQ-011 IRWrite  out  1  instruction register enable.
REQ-012 ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
REQ-013 ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=RD1.
REQ-014 ALUSrcB  out  2  ALU B select: 00=RD2, 01=ImmExt, 10=constant 4.
REQ-015 ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-016 ImmSrc  out  2  immediate format select.
REQ-017 RegWrite  out  1  register file write enable.
REQ-018 state  out  4  current FSM state, for debug and verification.

Function
REQ-019 Moore FSM; states: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10.
REQ-020 Encodings 11-15 transition to FETCH with all outputs 0.
REQ-021 Transitions: FETCH->DECODE.
REQ-022 DECODE transitions by op: 0000011 or 0100011 ->MEMADR; 0110011 ->EXECUTER; 0010011 ->EXECUTEI; 1100011 ->BEQ; 1101111 ->JAL; any other op ->FETCH.
REQ-023 Transitions: MEMADR->MEMREAD if op=0000011, else MEMWRITE.
REQ-024 Transitions: MEMREAD->MEMWB; MEMWB, MEMWRITE and BEQ ->FETCH; EXECUTER, EXECUTEI and JAL ->ALUWB; ALUWB->FETCH.
REQ-025 Per-state outputs (unlisted outputs are 0):
- FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
REQ-026 PCWrite = PCUpdate OR (Branch AND branch-taken); without CTRL_BNE_EN, branch-taken = zero.
REQ-027 ALU decode: ALUOp 00->000; ALUOp 01->001.
REQ-028 ALU decode, ALUOp 10 by funct3:
- 000 -> 001 when op[5]=1 and funct7b5=1, else 000.
- 010 -> 101.
- 110 -> 011.
- 111 -> 010.
- any other funct3 -> 000.
REQ-029 ImmSrc is combinational on op, independent of state: 0100011->01, 1100011->10, 1101111->11, all other op ->00.
REQ-030 Instruction latency: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles.

Reset
REQ-031 reset high at a rising edge forces state=FETCH, regardless of current state.
REQ-032 While reset is high, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 combinationally; other outputs follow state.

Configuration
REQ-033 Macro CTRL_BNE_EN: when defined, branch-taken = zero XOR funct3[0], which adds bne (funct3=001) on opcode 1100011; when undefined, bne executes as beq.

Verification
REQ-034 Test lw: reset, op=0000011 -> state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4; PCWrite=1 only in state 0.
REQ-035 Test sw: op=0100011 -> state sequence 0,1,2,5,0; MemWrite=1 and AdrSrc=1 in state 5; ImmSrc=01 throughout.
REQ-036 Test R-type: op=0110011, funct3=000, funct7b5=1 -> in state 6, ALUControl=001; next state 8 with RegWrite=1. Repeat with op=0010011 -> state 7, ALUControl=000.
REQ-037 Test beq: op=1100011, zero=1 -> PCWrite=1 in state 9. Repeat with zero=0 -> PCWrite=0. With CTRL_BNE_EN defined, funct3=001 and zero=0 -> PCWrite=1.
REQ-038 Test illegal opcode and reset: op=1111111 -> DECODE->FETCH. Reset asserted in MEMREAD -> state=0 after the next edge, and all write enables read 0 during reset.
